pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Drives the enable and no-op inputs of the
//  IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC enable.
//  - Resolves load-use hazards, taken-branch squashes, multi-cycle data-memory waits,

---
 rtl/pipe_hazard_ctrl_if.sv | 34 +++
 rtl/pipe_hazard_ctrl.sv | 41 ++++
 tb/tb_pipe_hazard_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard status from the pipeline and stage control back to it
interface pipe_hazard_ctrl_if #(parameter int REG_W = 3, parameter int CNT_W = 16);
  logic [REG_W-1:0] ifid_rs;
  logic [REG_W-1:0] ifid_rt;
  logic ifid_use_rs;
  logic ifid_use_rt;
  logic idex_memRead;
  logic [REG_W-1:0] idex_rd;
  logic branch_taken;
  logic exmem_memAcc;
  logic exmem_halt;
  logic dmem_stall;
  logic dmem_done;
  logic imem_stall;
  logic pc_en;
  logic ifid_en;
  logic ifid_noOp;
  logic idex_en;
  logic idex_noOp;
  logic exmem_stall;
  logic memwb_en;
  logic halted;
  logic [CNT_W-1:0] stall_cnt;
  modport slave (
    input ifid_rs, ifid_rt, ifid_use_rs, ifid_use_rt, idex_memRead, idex_rd, branch_taken,
    input exmem_memAcc, exmem_halt, dmem_stall, dmem_done, imem_stall,
    output pc_en, ifid_en, ifid_noOp, idex_en, idex_noOp, exmem_stall, memwb_en, halted, stall_cnt
  );
  modport master (
    output ifid_rs, ifid_rt, ifid_use_rs, ifid_use_rt, idex_memRead, idex_rd, branch_taken,
    output exmem_memAcc, exmem_halt, dmem_stall, dmem_done, imem_stall,
    input pc_en, ifid_en, ifid_noOp, idex_en, idex_noOp, exmem_stall, memwb_en, halted, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline with saturating stall counter
module pipe_hazard_ctrl #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  pipe_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT_WB, HALTED} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [REG_W-1:0] load_rd;
  logic load_use, mem_hold, halt_now, go, br, pc_en;
  always_comb begin
    load_rd = bus.idex_rd;
    load_use = bus.idex_memRead & ((bus.ifid_use_rs & (bus.ifid_rs == load_rd)) |
                                   (bus.ifid_use_rt & (bus.ifid_rt == load_rd)));
    mem_hold = (state == RUN) & bus.exmem_memAcc & bus.dmem_stall & ~bus.dmem_done;
    halt_now = ~rst & (state == RUN) & ~mem_hold & bus.exmem_halt;
    go = ~rst & (((state == RUN) & ~mem_hold & ~bus.exmem_halt) |
                 ((state == MEM_WAIT) & bus.dmem_done));
    br = bus.branch_taken;
    pc_en = go & (br | ~(load_use | bus.imem_stall));
    bus.pc_en = pc_en;
    bus.ifid_en = go & (br | ~load_use);
    bus.ifid_noOp = rst | (go & (br | (~load_use & bus.imem_stall)));
    bus.idex_en = go;
    bus.idex_noOp = rst | (go & (br | load_use));
    bus.exmem_stall = ~go;
    bus.memwb_en = go | halt_now;
    bus.halted = state == HALTED;
    bus.stall_cnt = cnt;
  end
  always_ff @(posedge clk) begin
    state <= rst ? RUN :
             state == RUN ? (mem_hold ? MEM_WAIT : bus.exmem_halt ? HALT_WB : RUN) :
             state == MEM_WAIT ? (bus.dmem_done ? RUN : MEM_WAIT) : HALTED;
    cnt <= rst ? '0 : (~pc_en & ~&cnt) ? cnt + 1'b1 : cnt;
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for the pipeline stall/flush sequencer
module tb_pipe_hazard_ctrl;
  localparam logic [9:0] F_RST = 10'h200, F_BR = 10'h100, F_ACC = 10'h080, F_DST = 10'h040;
  localparam logic [9:0] F_DDN = 10'h020, F_IST = 10'h010, F_HLT = 10'h008, F_MRD = 10'h004;
  localparam logic [9:0] F_URS = 10'h002, F_URT = 10'h001;
  localparam logic [7:0] NORM = 8'b11010010, RSTV = 8'b00101100, LU = 8'b00011010;
  localparam logic [7:0] BR = 8'b11111010, IM = 8'b01110010, HOLD = 8'b00000100;
  localparam logic [7:0] HLT1 = 8'b00000110, HALTD = 8'b00000101, RSTH = 8'b00101101;
  logic clk, rst;
  int n_vec = 0, n_bad = 0;
  logic [11:0] exp_q[$], obs_q[$];
  pipe_hazard_ctrl_if #(.REG_W(3), .CNT_W(4)) bus ();
  pipe_hazard_ctrl #(.REG_W(3), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic drive(input logic [9:0] f, input logic [2:0] rs, rt, rd);
    rst = f[9];
    bus.branch_taken = f[8];
    bus.exmem_memAcc = f[7];
    bus.dmem_stall = f[6];
    bus.dmem_done = f[5];
    bus.imem_stall = f[4];
    bus.exmem_halt = f[3];
    bus.idex_memRead = f[2];
    bus.ifid_use_rs = f[1];
    bus.ifid_use_rt = f[0];
    bus.ifid_rs = rs;
    bus.ifid_rt = rt;
    bus.idex_rd = rd;
  endtask
  task automatic cyc(input logic [9:0] f, input logic [2:0] rs, rt, rd, input logic [7:0] ec, input logic [3:0] en);
    @(posedge clk);
    #1;
    drive(f, rs, rt, rd);
    exp_q.push_back({ec, en});
    @(negedge clk);
    obs_q.push_back({bus.pc_en, bus.ifid_en, bus.ifid_noOp, bus.idex_en, bus.idex_noOp,
                     bus.exmem_stall, bus.memwb_en, bus.halted, bus.stall_cnt});
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    drive(F_RST, 0, 0, 0);
  endtask
  task automatic test_reset();
    logic [11:0] e, o;
    cyc(F_RST | F_BR | F_IST, 0, 0, 0, RSTV, 0);
    cyc(F_RST | F_MRD | F_URS, 3, 0, 3, RSTV, 0);
    cyc(0, 0, 0, 0, NORM, 0);
    for (int i = 0; exp_q.size() != 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL reset[%0d]: got ctrl=%b cnt=%0d, expected ctrl=%b cnt=%0d", i, o[11:4], o[3:0], e[11:4], e[3:0]);
      end
    end
  endtask
  task automatic test_load_use();
    logic [11:0] e, o;
    do_reset();
    cyc(F_MRD | F_URS, 3, 0, 3, LU, 0);
    cyc(0, 0, 0, 0, NORM, 1);
    cyc(F_MRD | F_URT, 0, 5, 5, LU, 1);
    cyc(F_MRD | F_URS, 2, 0, 3, NORM, 2);
    cyc(F_MRD, 3, 3, 3, NORM, 2);
    cyc(F_URS | F_URT, 3, 3, 3, NORM, 2);
    cyc(F_MRD | F_URS | F_URT, 1, 6, 6, LU, 2);
    cyc(0, 0, 0, 0, NORM, 3);
    for (int i = 0; exp_q.size() != 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL load_use[%0d]: got ctrl=%b cnt=%0d, expected ctrl=%b cnt=%0d", i, o[11:4], o[3:0], e[11:4], e[3:0]);
      end
    end
  endtask
  task automatic test_branch();
    logic [11:0] e, o;
    do_reset();
    cyc(F_BR | F_MRD | F_URS, 3, 0, 3, BR, 0);
    cyc(F_BR | F_IST, 0, 0, 0, BR, 0);
    cyc(F_BR | F_IST | F_MRD | F_URT, 0, 4, 4, BR, 0);
    cyc(F_IST, 0, 0, 0, IM, 0);
    cyc(0, 0, 0, 0, NORM, 1);
    for (int i = 0; exp_q.size() != 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL branch[%0d]: got ctrl=%b cnt=%0d, expected ctrl=%b cnt=%0d", i, o[11:4], o[3:0], e[11:4], e[3:0]);
      end
    end
  endtask
  task automatic test_dmem_wait();
    logic [11:0] e, o;
    do_reset();
    repeat (3) cyc(F_ACC | F_DST, 0, 0, 0, HOLD, 4'(n_vec - n_vec + exp_q.size()));
    cyc(F_ACC | F_DDN, 0, 0, 0, NORM, 3);
    cyc(0, 0, 0, 0, NORM, 3);
    cyc(F_ACC | F_DST | F_DDN, 0, 0, 0, NORM, 3);
    cyc(F_DST, 0, 0, 0, NORM, 3);
    cyc(F_ACC | F_DST | F_HLT, 0, 0, 0, HOLD, 3);
    cyc(F_DDN, 0, 0, 0, NORM, 4);
    cyc(0, 0, 0, 0, NORM, 4);
    for (int i = 0; exp_q.size() != 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL dmem_wait[%0d]: got ctrl=%b cnt=%0d, expected ctrl=%b cnt=%0d", i, o[11:4], o[3:0], e[11:4], e[3:0]);
      end
    end
  endtask
  task automatic test_simultaneous();
    logic [11:0] e, o;
    do_reset();
    cyc(F_BR | F_ACC | F_DST, 0, 0, 0, HOLD, 0);
    cyc(F_BR | F_DST, 0, 0, 0, HOLD, 1);
    cyc(F_BR | F_DDN, 0, 0, 0, BR, 2);
    cyc(0, 0, 0, 0, NORM, 2);
    cyc(F_ACC | F_DST, 0, 0, 0, HOLD, 2);
    cyc(F_MRD | F_URS | F_DDN, 3, 0, 3, LU, 3);
    cyc(0, 0, 0, 0, NORM, 4);
    cyc(F_ACC | F_DST, 0, 0, 0, HOLD, 4);
    cyc(F_IST | F_DDN, 0, 0, 0, IM, 5);
    cyc(0, 0, 0, 0, NORM, 6);
    for (int i = 0; exp_q.size() != 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL simultaneous[%0d]: got ctrl=%b cnt=%0d, expected ctrl=%b cnt=%0d", i, o[11:4], o[3:0], e[11:4], e[3:0]);
      end
    end
  endtask
  task automatic test_halt();
    logic [11:0] e, o;
    do_reset();
    cyc(F_HLT, 0, 0, 0, HLT1, 0);
    cyc(0, 0, 0, 0, HOLD, 1);
    cyc(0, 0, 0, 0, HALTD, 2);
    cyc(F_IST, 0, 0, 0, HALTD, 3);
    cyc(F_BR | F_DDN | F_ACC, 0, 0, 0, HALTD, 4);
    cyc(F_RST, 0, 0, 0, RSTH, 5);
    cyc(0, 0, 0, 0, NORM, 0);
    for (int i = 0; exp_q.size() != 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL halt[%0d]: got ctrl=%b cnt=%0d, expected ctrl=%b cnt=%0d", i, o[11:4], o[3:0], e[11:4], e[3:0]);
      end
    end
  endtask
  task automatic test_reset_wait_saturate();
    logic [11:0] e, o;
    do_reset();
    cyc(F_ACC | F_DST, 0, 0, 0, HOLD, 0);
    cyc(F_DST, 0, 0, 0, HOLD, 1);
    cyc(F_RST | F_DST, 0, 0, 0, RSTV, 2);
    cyc(0, 0, 0, 0, NORM, 0);
    do_reset();
    for (int k = 0; k < 20; k++) cyc(F_IST, 0, 0, 0, IM, (k > 15) ? 4'd15 : 4'(k));
    cyc(0, 0, 0, 0, NORM, 15);
    cyc(F_IST, 0, 0, 0, IM, 15);
    cyc(0, 0, 0, 0, NORM, 15);
    for (int i = 0; exp_q.size() != 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL reset_wait_sat[%0d]: got ctrl=%b cnt=%0d, expected ctrl=%b cnt=%0d", i, o[11:4], o[3:0], e[11:4], e[3:0]);
      end
    end
  endtask
  initial begin
    drive(F_RST, 0, 0, 0);
    repeat (2) @(posedge clk);
    test_reset();
    test_load_use();
    test_branch();
    test_dmem_wait();
    test_simultaneous();
    test_halt();
    test_reset_wait_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
